// File: rtl/volume_pkg.sv
// Purpose: shared constants and types for the front-panel volume key controller.
// Contents: volume code limits, key index constants, repeat FSM state encoding,
//           and a helper for sizing the repeat timer.
package volume_pkg;

    localparam logic [2:0] VOL_MAX    = 3'd0;
    localparam logic [2:0] VOL_SILENT = 3'd7;

    localparam int unsigned NUM_KEYS = 3;
    localparam int unsigned KEY_UP   = 0;
    localparam int unsigned KEY_DOWN = 1;
    localparam int unsigned KEY_MUTE = 2;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Larger of two cycle counts; sizes the shared repeat timer.
    function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronise one raw asynchronous key and debounce it.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   raw   - raw key input (asynchronous, active-high)
//   level - debounced key level
//   press - one-cycle pulse, high in the first cycle that level reads 1
module key_debounce
    import volume_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; once the count has reached the
    // limit the level flips on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/volume_key_ctrl.sv
// Purpose: turn up/down/mute front-panel keys into the 3-bit attenuation code
//          for the stereo volume stage, with hold-to-repeat on up/down.
// Ports:
//   clk           - system clock
//   reset         - asynchronous active-high reset
//   key_up        - raw key, louder (lower code)
//   key_down      - raw key, quieter (higher code)
//   key_mute      - raw key, toggles mute
//   volume_ctrl   - attenuation code, 0 = full scale, 7 = silence (registered)
//   muted         - mute flag (registered)
//   level_changed - one-cycle pulse whenever volume_ctrl changes (registered)
module volume_key_ctrl
    import volume_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 24000000,
    parameter int unsigned REPEAT_RATE     = 6000000,
    parameter logic [2:0]  RESET_LEVEL     = 3'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_mute,
    output logic [2:0] volume_ctrl,
    output logic       muted,
    output logic       level_changed
);

    localparam int unsigned TW = $clog2(max_cycles(REPEAT_DELAY, REPEAT_RATE) + 1);

    logic          up_level;
    logic          dn_level;
    logic          up_press;
    logic          dn_press;
    logic          mute_press;
    logic          unused_mute_level;

    rpt_state_t    state;
    rpt_state_t    state_n;
    logic [TW-1:0] timer;
    logic          rkey_dn;
    logic          held;
    logic          other;
    logic          expire;
    logic          start_up;
    logic          start_dn;
    logic          step_c;
    logic          load_delay;
    logic          load_rate;

    logic          up_evt;
    logic          dn_evt;
    logic [2:0]    lvl;
    logic [2:0]    lvl_n;
    logic          muted_n;
    logic [2:0]    vol_n;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .raw   (key_up),
        .level (up_level),
        .press (up_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk   (clk),
        .reset (reset),
        .raw   (key_down),
        .level (dn_level),
        .press (dn_press)
    );

    // Mute only acts on its press edge; its level has no consumer.
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mute (
        .clk   (clk),
        .reset (reset),
        .raw   (key_mute),
        .level (unused_mute_level),
        .press (mute_press)
    );

    // Repeat qualifiers: latched key still held, opposite key not pressed.
    assign held     = rkey_dn ? dn_level : up_level;
    assign other    = rkey_dn ? up_level : dn_level;
    assign expire   = (timer == TW'(1));
    assign start_up = up_press & ~dn_press;
    assign start_dn = dn_press & ~up_press;

    // Repeat FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RPT_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Repeat FSM next state; release or opposite key beats timer expiry.
    always_comb begin
        state_n = state;
        case (state)
            RPT_IDLE:   if (start_up || start_dn) state_n = RPT_DELAY;
            RPT_DELAY: begin
                if (!held || other) state_n = RPT_IDLE;
                else if (expire)    state_n = RPT_REPEAT;
            end
            RPT_REPEAT: if (!held || other) state_n = RPT_IDLE;
            default:    state_n = RPT_IDLE;
        endcase
    end

    // Repeat FSM outputs: step request and timer load controls.
    always_comb begin
        step_c     = 1'b0;
        load_delay = 1'b0;
        load_rate  = 1'b0;
        case (state)
            RPT_IDLE: load_delay = start_up || start_dn;
            RPT_DELAY, RPT_REPEAT: begin
                if (held && !other && expire) begin
                    step_c    = 1'b1;
                    load_rate = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Repeat timer and latched key; expiry is the cycle the timer reads 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer   <= '0;
            rkey_dn <= 1'b0;
        end else if (load_delay) begin
            timer   <= TW'(REPEAT_DELAY);
            rkey_dn <= start_dn;
        end else if (load_rate) begin
            timer <= TW'(REPEAT_RATE);
        end else if (state != RPT_IDLE) begin
            timer <= timer - TW'(1);
        end
    end

    // Event resolution: mute wins, up+down cancel, up/down while muted only unmutes.
    always_comb begin
        up_evt  = up_press | (step_c & ~rkey_dn);
        dn_evt  = dn_press | (step_c & rkey_dn);
        lvl_n   = lvl;
        muted_n = muted;
        if (mute_press) begin
            muted_n = ~muted;
        end else if (up_evt ^ dn_evt) begin
            if (muted) begin
                muted_n = 1'b0;
            end else if (up_evt) begin
                if (lvl != VOL_MAX) lvl_n = lvl - 3'd1;
            end else begin
                if (lvl != VOL_SILENT) lvl_n = lvl + 3'd1;
            end
        end
        vol_n = muted_n ? VOL_SILENT : lvl_n;
    end

    // Level, mute flag and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl           <= RESET_LEVEL;
            muted         <= 1'b0;
            volume_ctrl   <= RESET_LEVEL;
            level_changed <= 1'b0;
        end else begin
            lvl           <= lvl_n;
            muted         <= muted_n;
            volume_ctrl   <= vol_n;
            level_changed <= (vol_n != volume_ctrl);
        end
    end

endmodule

// File: tb/tb_volume_key_ctrl.sv
// Purpose: self-checking bench for volume_key_ctrl with short timing parameters.
// A behavioural model tracks key history, hold durations and level rules and
// is compared against the DUT every cycle, alongside directed spot checks.
module tb_volume_key_ctrl;
    import volume_pkg::*;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RR = 8;
    localparam logic [2:0]  RL = 3'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic       key_mute = 1'b0;
    logic [2:0] volume_ctrl;
    logic       muted;
    logic       level_changed;

    int errors = 0;
    int checks = 0;

    volume_key_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .RESET_LEVEL    (RL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_up       (key_up),
        .key_down     (key_down),
        .key_mute     (key_mute),
        .volume_ctrl  (volume_ctrl),
        .muted        (muted),
        .level_changed(level_changed)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit         m_s1[3];
    bit         m_s2[3];
    bit         m_deb[3];
    bit         m_pr[3];
    int         m_run[3];
    int         m_lvl;
    bit         m_muted;
    bit         m_lc;
    logic [2:0] m_vol;
    int         m_rkey;
    int         m_hold;

    task automatic model_step();
        bit raw_now[3];
        bit st_u;
        bit st_d;
        bit up_e;
        bit dn_e;
        int nv;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_deb[k] = 0; m_pr[k] = 0; m_run[k] = 0;
            end
            m_lvl = int'(RL); m_muted = 0; m_vol = RL; m_lc = 0; m_rkey = -1; m_hold = 0;
        end else begin
            raw_now[KEY_UP]   = key_up;
            raw_now[KEY_DOWN] = key_down;
            raw_now[KEY_MUTE] = key_mute;
            // hold-to-repeat measured as cycles since the latching press
            st_u = 0;
            st_d = 0;
            if (m_rkey < 0) begin
                if (m_pr[KEY_UP] != m_pr[KEY_DOWN]) begin
                    m_rkey = m_pr[KEY_UP] ? KEY_UP : KEY_DOWN;
                    m_hold = 0;
                end
            end else if (!m_deb[m_rkey] || m_deb[(m_rkey == KEY_UP) ? KEY_DOWN : KEY_UP]) begin
                m_rkey = -1;
            end else begin
                m_hold++;
                if (m_hold == RD || (m_hold > RD && ((m_hold - RD) % RR) == 0)) begin
                    if (m_rkey == KEY_UP) st_u = 1; else st_d = 1;
                end
            end
            up_e = m_pr[KEY_UP] | st_u;
            dn_e = m_pr[KEY_DOWN] | st_d;
            if (m_pr[KEY_MUTE]) m_muted = !m_muted;
            else if (up_e != dn_e) begin
                if (m_muted) m_muted = 0;
                else if (up_e) m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
                else m_lvl = (m_lvl < 7) ? m_lvl + 1 : 7;
            end
            nv = m_muted ? 7 : m_lvl;
            m_lc = (3'(nv) != m_vol);
            m_vol = 3'(nv);
            // debounce: level flips once more than DB consecutive cycles disagree
            for (int k = 0; k < 3; k++) begin
                m_pr[k] = 0;
                if (m_s2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] > DB) begin
                        m_deb[k] = m_s2[k];
                        m_run[k] = 0;
                        m_pr[k]  = m_deb[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = raw_now[k];
            end
        end
    endtask

    always @(posedge clk or posedge reset) model_step();

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_keys(input bit u, input bit d, input bit m);
        key_up   = u;
        key_down = d;
        key_mute = m;
    endtask

    task automatic apply_reset();
        set_keys(0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int lc_cnt = 0;
        apply_reset();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if ({volume_ctrl, muted, level_changed} !== {m_vol, m_muted, m_lc}) begin
                errors++;
                $display("FAIL reset_model c=%0d dut=%0d/%0b/%0b model=%0d/%0b/%0b",
                         c, volume_ctrl, muted, level_changed, m_vol, m_muted, m_lc);
            end
            if (level_changed === 1'b1) lc_cnt++;
        end
        checks++;
        if ({volume_ctrl, muted} !== {RL, 1'b0}) begin
            errors++;
            $display("FAIL reset_values vol=%0d muted=%0b expected vol=%0d muted=0", volume_ctrl, muted, RL);
        end
        checks++;
        if (lc_cnt != 0) begin
            errors++;
            $display("FAIL reset_no_pulse pulses=%0d expected 0", lc_cnt);
        end
    endtask

    task automatic test_press_glitch();
        int lc_cnt = 0;
        set_keys(1, 0, 0);
        for (int c = 0; c < 30; c++) begin
            if (c == 10) set_keys(0, 0, 0);
            @(negedge clk);
            checks++;
            if ({volume_ctrl, muted, level_changed} !== {m_vol, m_muted, m_lc}) begin
                errors++;
                $display("FAIL press_model c=%0d dut=%0d/%0b/%0b model=%0d/%0b/%0b",
                         c, volume_ctrl, muted, level_changed, m_vol, m_muted, m_lc);
            end
            if (c == 6) begin
                checks++;
                if (volume_ctrl !== 3'd2) begin
                    errors++;
                    $display("FAIL press_edge6 vol=%0d expected 2", volume_ctrl);
                end
            end
            if (c == 7) begin
                checks++;
                if ({volume_ctrl, level_changed} !== {3'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL press_edge7 vol=%0d lc=%0b expected vol=1 lc=1", volume_ctrl, level_changed);
                end
            end
        end
        // 3-cycle glitch on down must be rejected
        set_keys(0, 1, 0);
        for (int c = 0; c < 25; c++) begin
            if (c == 3) set_keys(0, 0, 0);
            @(negedge clk);
            checks++;
            if ({volume_ctrl, muted, level_changed} !== {m_vol, m_muted, m_lc}) begin
                errors++;
                $display("FAIL glitch_model c=%0d dut=%0d/%0b/%0b model=%0d/%0b/%0b",
                         c, volume_ctrl, muted, level_changed, m_vol, m_muted, m_lc);
            end
            if (level_changed === 1'b1) lc_cnt++;
        end
        checks++;
        if (volume_ctrl !== 3'd1 || lc_cnt != 0) begin
            errors++;
            $display("FAIL glitch_reject vol=%0d pulses=%0d expected vol=1 pulses=0", volume_ctrl, lc_cnt);
        end
    endtask

    task automatic test_hold_repeat();
        int lc_cnt = 0;
        apply_reset();
        set_keys(1, 0, 0);
        for (int c = 0; c < 85; c++) begin
            if (c == 60) set_keys(0, 0, 0);
            @(negedge clk);
            checks++;
            if ({volume_ctrl, muted, level_changed} !== {m_vol, m_muted, m_lc}) begin
                errors++;
                $display("FAIL hold_model c=%0d dut=%0d/%0b/%0b model=%0d/%0b/%0b",
                         c, volume_ctrl, muted, level_changed, m_vol, m_muted, m_lc);
            end
            if (level_changed === 1'b1) lc_cnt++;
            if (c == 27) begin
                checks++;
                if (volume_ctrl !== 3'd0) begin
                    errors++;
                    $display("FAIL hold_first_repeat vol=%0d expected 0", volume_ctrl);
                end
            end
        end
        checks++;
        if (volume_ctrl !== 3'd0 || lc_cnt != 2) begin
            errors++;
            $display("FAIL hold_saturate vol=%0d pulses=%0d expected vol=0 pulses=2", volume_ctrl, lc_cnt);
        end
    endtask

    task automatic test_mute();
        logic [2:0] seg_keys[4] = '{3'b010, 3'b100, 3'b010, 3'b100};
        logic [2:0] exp_vol[4]  = '{3'd3, 3'd7, 3'd3, 3'd7};
        bit         exp_mute[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            set_keys(seg_keys[s][0], seg_keys[s][1], seg_keys[s][2]);
            for (int c = 0; c < 25; c++) begin
                if (c == 10) set_keys(0, 0, 0);
                @(negedge clk);
                checks++;
                if ({volume_ctrl, muted, level_changed} !== {m_vol, m_muted, m_lc}) begin
                    errors++;
                    $display("FAIL mute_model s=%0d c=%0d dut=%0d/%0b/%0b model=%0d/%0b/%0b",
                             s, c, volume_ctrl, muted, level_changed, m_vol, m_muted, m_lc);
                end
            end
            checks++;
            if ({volume_ctrl, muted} !== {exp_vol[s], exp_mute[s]}) begin
                errors++;
                $display("FAIL mute_step%0d vol=%0d muted=%0b expected vol=%0d muted=%0b",
                         s, volume_ctrl, muted, exp_vol[s], exp_mute[s]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] seg_keys[2] = '{3'b011, 3'b101};
        logic [2:0] exp_vol[2]  = '{3'd2, 3'd7};
        bit         exp_mute[2] = '{1'b0, 1'b1};
        apply_reset();
        for (int s = 0; s < 2; s++) begin
            set_keys(seg_keys[s][0], seg_keys[s][1], seg_keys[s][2]);
            for (int c = 0; c < 25; c++) begin
                if (c == 10) set_keys(0, 0, 0);
                @(negedge clk);
                checks++;
                if ({volume_ctrl, muted, level_changed} !== {m_vol, m_muted, m_lc}) begin
                    errors++;
                    $display("FAIL simul_model s=%0d c=%0d dut=%0d/%0b/%0b model=%0d/%0b/%0b",
                             s, c, volume_ctrl, muted, level_changed, m_vol, m_muted, m_lc);
                end
            end
            checks++;
            if ({volume_ctrl, muted} !== {exp_vol[s], exp_mute[s]}) begin
                errors++;
                $display("FAIL simul_step%0d vol=%0d muted=%0b expected vol=%0d muted=%0b",
                         s, volume_ctrl, muted, exp_vol[s], exp_mute[s]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        set_keys(0, 1, 0);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if ({volume_ctrl, muted, level_changed} !== {m_vol, m_muted, m_lc}) begin
                errors++;
                $display("FAIL rsthold_model c=%0d dut=%0d/%0b/%0b model=%0d/%0b/%0b",
                         c, volume_ctrl, muted, level_changed, m_vol, m_muted, m_lc);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({volume_ctrl, muted, level_changed} !== {RL, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rsthold_in_reset c=%0d dut=%0d/%0b/%0b expected %0d/0/0",
                         c, volume_ctrl, muted, level_changed, RL);
            end
        end
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (volume_ctrl !== ((c >= 8) ? 3'd3 : 3'd2) || level_changed !== (c == 8)) begin
                errors++;
                $display("FAIL rsthold_redebounce c=%0d vol=%0d lc=%0b expected vol=%0d lc=%0b",
                         c, volume_ctrl, level_changed, (c >= 8) ? 3 : 2, (c == 8));
            end
        end
        set_keys(0, 0, 0);
    endtask

    task automatic test_random();
        logic [2:0] keys;
        int         dur;
        apply_reset();
        for (int s = 0; s < 60; s++) begin
            keys = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            dur  = $urandom_range(1, 45);
            set_keys(keys[0], keys[1], keys[2]);
            for (int c = 0; c < dur; c++) begin
                @(negedge clk);
                checks++;
                if ({volume_ctrl, muted, level_changed} !== {m_vol, m_muted, m_lc}) begin
                    errors++;
                    $display("FAIL random_model s=%0d c=%0d keys=%b dut=%0d/%0b/%0b model=%0d/%0b/%0b",
                             s, c, keys, volume_ctrl, muted, level_changed, m_vol, m_muted, m_lc);
                end
            end
        end
        set_keys(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_press_glitch();
        test_hold_repeat();
        test_mute();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
